// File: rtl/search_result_recorder.sv
// Word-search sequencer: tracks word boundaries/indices on the character stream and
// records whole-word match indices into a DEPTH-slot buffer. Optional irq: SEARCH_RESULT_IRQ_EN.
module search_result_recorder #(
  parameter int DEPTH    = 8,
  parameter int ID_WIDTH = 8
) (
  input  logic                         aclk,
  input  logic                         aresetn,
  input  logic                         clear,
  input  logic [7:0]                   word_size,
  input  logic                         s_axis_tvalid,
  input  logic [7:0]                   s_axis_tdata,
  input  logic                         s_axis_tuser,
  input  logic                         match,
  output logic [DEPTH*ID_WIDTH-1:0]    result_ids,
  output logic [$clog2(DEPTH):0]       result_count,
  output logic                         overflow,
  output logic                         busy,
`ifdef SEARCH_RESULT_IRQ_EN
  output logic                         irq,
`endif
  output logic                         done
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, IN_WORD, GAP, DONE} state_e;

  state_e                            state_q, state_d, st;
  logic [7:0]                        char_cnt_q, char_cnt_d, cnt_inc;
  logic [ID_WIDTH-1:0]               word_idx_q, word_idx_d;
  logic                              hit_q, hit_d;
  logic                              started_q, started_d;
  logic [DEPTH-1:0][ID_WIDTH-1:0]    slots_q, slots_d;
  logic [CW-1:0]                     count_q, count_d;
  logic                              ovf_q, ovf_d;
  logic                              busy_q, busy_d;
  logic                              done_q, done_d;
  logic                              is_sep, is_chr, is_end, commit_ok, do_commit;
`ifdef SEARCH_RESULT_IRQ_EN
  logic                              irq_q, irq_d;
`endif

  always_comb begin
    state_d    = state_q;
    char_cnt_d = char_cnt_q;
    word_idx_d = word_idx_q;
    hit_d      = hit_q;
    started_d  = started_q;
    slots_d    = slots_q;
    count_d    = count_q;
    ovf_d      = ovf_q;
    do_commit  = 1'b0;
    st         = state_q;

    is_end    = s_axis_tvalid && s_axis_tuser;
    is_sep    = s_axis_tvalid && !s_axis_tuser && (s_axis_tdata == 8'h20);
    is_chr    = s_axis_tvalid && !s_axis_tuser && (s_axis_tdata != 8'h20);
    commit_ok = hit_q && (char_cnt_q == word_size) && (word_size != 8'd0);
    cnt_inc   = (char_cnt_q == 8'hFF) ? 8'hFF : char_cnt_q + 8'd1;

    // A non-terminator beat after DONE opens a new text, then is handled as in IDLE.
    if (state_q == DONE && (is_chr || is_sep)) begin
      slots_d    = '1;
      count_d    = '0;
      ovf_d      = 1'b0;
      word_idx_d = '0;
      started_d  = 1'b0;
      st         = IDLE;
    end

    case (st)
      IDLE: begin
        if (is_chr) begin
          state_d    = IN_WORD;
          char_cnt_d = 8'd1;
          hit_d      = match && (word_size == 8'd1);
          started_d  = 1'b1;
        end else if (is_sep) begin
          state_d = GAP;
        end else if (is_end) begin
          state_d = DONE;
        end
      end
      IN_WORD: begin
        if (is_chr) begin
          char_cnt_d = cnt_inc;
          if (match && cnt_inc == word_size) hit_d = 1'b1;
          else if (cnt_inc > word_size)      hit_d = 1'b0;
        end else if (is_sep || is_end) begin
          do_commit = commit_ok;
          state_d   = is_end ? DONE : GAP;
        end
      end
      GAP: begin
        if (is_chr) begin
          // Leading separators precede word 0, so only advance once a word has been seen.
          if (started_q && word_idx_q != '1) word_idx_d = word_idx_q + 1'b1;
          state_d    = IN_WORD;
          char_cnt_d = 8'd1;
          hit_d      = match && (word_size == 8'd1);
          started_d  = 1'b1;
        end else if (is_end) begin
          state_d = DONE;
        end
      end
      default: ;
    endcase

    if (do_commit) begin
      if (count_q < DEPTH_C) begin
        for (int k = 0; k < DEPTH; k++)
          if (count_q == CW'(k)) slots_d[k] = word_idx_q;
        count_d = count_q + 1'b1;
      end else begin
        ovf_d = 1'b1;
      end
    end

`ifdef SEARCH_RESULT_IRQ_EN
    irq_d = (state_d == DONE) && (state_q != DONE) && ((count_d != '0) || ovf_d);
`endif

    if (clear) begin
      state_d    = IDLE;
      char_cnt_d = '0;
      word_idx_d = '0;
      hit_d      = 1'b0;
      started_d  = 1'b0;
      slots_d    = '1;
      count_d    = '0;
      ovf_d      = 1'b0;
`ifdef SEARCH_RESULT_IRQ_EN
      irq_d      = 1'b0;
`endif
    end

    busy_d = (state_d == IN_WORD) || (state_d == GAP);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q    <= IDLE;
      char_cnt_q <= '0;
      word_idx_q <= '0;
      hit_q      <= 1'b0;
      started_q  <= 1'b0;
      slots_q    <= '1;
      count_q    <= '0;
      ovf_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef SEARCH_RESULT_IRQ_EN
      irq_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      char_cnt_q <= char_cnt_d;
      word_idx_q <= word_idx_d;
      hit_q      <= hit_d;
      started_q  <= started_d;
      slots_q    <= slots_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
`ifdef SEARCH_RESULT_IRQ_EN
      irq_q      <= irq_d;
`endif
    end
  end

  assign result_ids   = slots_q;
  assign result_count = count_q;
  assign overflow     = ovf_q;
  assign busy         = busy_q;
  assign done         = done_q;
`ifdef SEARCH_RESULT_IRQ_EN
  assign irq          = irq_q;
`endif

endmodule

// File: tb/tb_search_result_recorder.sv
// Self-checking bench for search_result_recorder: directed scenarios plus randomized
// texts checked against a word-level reference model.
module tb_search_result_recorder;

  logic        aclk = 1'b0;
  logic        aresetn, clear;
  logic [7:0]  word_size;
  logic        s_axis_tvalid, s_axis_tuser, match;
  logic [7:0]  s_axis_tdata;
  logic [63:0] result_ids;
  logic [3:0]  result_count;
  logic        overflow, busy, done;
`ifdef SEARCH_RESULT_IRQ_EN
  logic        irq;
`endif

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_slot [8];
  int         exp_cnt;
  logic       exp_ovf;

  always #5 aclk = ~aclk;

  search_result_recorder #(.DEPTH(8), .ID_WIDTH(8)) dut (
    .aclk(aclk), .aresetn(aresetn), .clear(clear), .word_size(word_size),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tdata(s_axis_tdata),
    .s_axis_tuser(s_axis_tuser), .match(match),
    .result_ids(result_ids), .result_count(result_count), .overflow(overflow),
    .busy(busy),
`ifdef SEARCH_RESULT_IRQ_EN
    .irq(irq),
`endif
    .done(done)
  );

  task automatic beat(input logic [7:0] d, input logic u, input logic m, input logic c);
    s_axis_tvalid = 1'b1; s_axis_tdata = d; s_axis_tuser = u; match = m; clear = c;
    @(posedge aclk); #1;
    s_axis_tvalid = 1'b0; s_axis_tdata = 8'h00; s_axis_tuser = 1'b0; match = 1'b0; clear = 1'b0;
  endtask

  task automatic idle_cycle();
    s_axis_tvalid = 1'b0; match = 1'($urandom_range(0, 1)); s_axis_tdata = 8'h61;
    @(posedge aclk); #1;
    match = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1; @(posedge aclk); #1; clear = 1'b0;
  endtask

  task automatic send_str(input string s, input byte mch);
    for (int i = 0; i < s.len(); i++) beat(s[i], 1'b0, s[i] == mch, 1'b0);
  endtask

  // Word-level reference: a word is recorded when its length equals word_size and
  // the comparator fired on its last character.
  task automatic model_text(input int ws, input int lens[$], input bit lastm[$]);
    exp_cnt = 0; exp_ovf = 1'b0;
    for (int k = 0; k < 8; k++) exp_slot[k] = 8'hFF;
    for (int w = 0; w < lens.size(); w++) begin
      if (ws != 0 && lens[w] == ws && lastm[w]) begin
        if (exp_cnt < 8) begin exp_slot[exp_cnt] = 8'(w); exp_cnt++; end
        else exp_ovf = 1'b1;
      end
    end
  endtask

  task automatic test_reset();
    aresetn = 1'b0; #12;
    checks++; if (result_count !== 4'd0 || overflow !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL reset_flags got cnt=%0d ovf=%b busy=%b done=%b want 0", result_count, overflow, busy, done); end
    checks++; if (result_ids !== {64{1'b1}}) begin
      errors++; $display("FAIL reset_slots got %h want all ones", result_ids); end
    aresetn = 1'b1; #3; @(posedge aclk); #1;
    word_size = 8'd2;
    send_str("ab", "b");
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midword_busy got %b want 1", busy); end
    #2 aresetn = 1'b0; #1;
    checks++; if (busy !== 1'b0 || result_count !== 4'd0) begin
      errors++; $display("FAIL async_reset got busy=%b cnt=%0d want 0 0", busy, result_count); end
    #2 aresetn = 1'b1; @(posedge aclk); #1;
    beat(8'h00, 1'b1, 1'b0, 1'b0);
    checks++; if (result_count !== 4'd0 || done !== 1'b1) begin
      errors++; $display("FAIL reset_nocommit got cnt=%0d done=%b want 0 1", result_count, done); end
  endtask

  task automatic test_cat_dog();
    do_clear();
    word_size = 8'd3;
    send_str("cat dog cat", "t");
    beat(8'h00, 1'b1, 1'b0, 1'b0);
    checks++; if (result_count !== 4'd2 || done !== 1'b1 || overflow !== 1'b0) begin
      errors++; $display("FAIL catdog_flags got cnt=%0d done=%b ovf=%b want 2 1 0", result_count, done, overflow); end
    for (int k = 0; k < 8; k++) begin
      logic [7:0] e;
      e = (k == 0) ? 8'd0 : (k == 1) ? 8'd2 : 8'hFF;
      checks++; if (result_ids[k*8 +: 8] !== e) begin
        errors++; $display("FAIL catdog_slot%0d got %h want %h", k, result_ids[k*8 +: 8], e); end
    end
`ifdef SEARCH_RESULT_IRQ_EN
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL catdog_irq got %b want 1", irq); end
    @(posedge aclk); #1;
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL catdog_irq_pulse got %b want 0", irq); end
`endif
    beat(8'h00, 1'b1, 1'b1, 1'b0);
    checks++; if (done !== 1'b1 || result_count !== 4'd2) begin
      errors++; $display("FAIL done_tuser_ignored got done=%b cnt=%0d want 1 2", done, result_count); end
`ifdef SEARCH_RESULT_IRQ_EN
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL repeat_tuser_irq got %b want 0", irq); end
`endif
  endtask

  task automatic test_cats();
    do_clear();
    word_size = 8'd3;
    send_str("cats", "t");
    beat(8'h00, 1'b1, 1'b0, 1'b0);
    checks++; if (result_count !== 4'd0 || done !== 1'b1 || result_ids[7:0] !== 8'hFF) begin
      errors++; $display("FAIL cats got cnt=%0d done=%b slot0=%h want 0 1 ff", result_count, done, result_ids[7:0]); end
`ifdef SEARCH_RESULT_IRQ_EN
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL cats_irq got %b want 0", irq); end
`endif
    do_clear();
    send_str("cat dog cat", 8'h00);
    beat(8'h00, 1'b1, 1'b0, 1'b0);
    checks++; if (result_count !== 4'd0) begin errors++; $display("FAIL nomatch_cnt got %0d want 0", result_count); end
`ifdef SEARCH_RESULT_IRQ_EN
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL nomatch_irq got %b want 0", irq); end
`endif
  endtask

  task automatic test_overflow();
    do_clear();
    word_size = 8'd1;
    send_str("a a a a a a a a a", "a");
    beat(8'h00, 1'b1, 1'b0, 1'b0);
    checks++; if (result_count !== 4'd8 || overflow !== 1'b1) begin
      errors++; $display("FAIL ovf_flags got cnt=%0d ovf=%b want 8 1", result_count, overflow); end
    for (int k = 0; k < 8; k++) begin
      checks++; if (result_ids[k*8 +: 8] !== 8'(k)) begin
        errors++; $display("FAIL ovf_slot%0d got %h want %h", k, result_ids[k*8 +: 8], 8'(k)); end
    end
  endtask

  task automatic test_restart();
    beat(8'h78, 1'b0, 1'b0, 1'b0);
    checks++; if (result_ids !== {64{1'b1}} || result_count !== 4'd0 || overflow !== 1'b0 || busy !== 1'b1 || done !== 1'b0) begin
      errors++; $display("FAIL restart got ids=%h cnt=%0d ovf=%b busy=%b done=%b", result_ids, result_count, overflow, busy, done); end
    send_str(" b", "b");
    beat(8'h00, 1'b1, 1'b0, 1'b0);
    checks++; if (result_count !== 4'd1 || result_ids[7:0] !== 8'd1) begin
      errors++; $display("FAIL restart_idx got cnt=%0d slot0=%h want 1 01", result_count, result_ids[7:0]); end
  endtask

  task automatic test_clear();
    do_clear();
    word_size = 8'd3;
    send_str("cat", "t");
    beat(8'h20, 1'b0, 1'b0, 1'b1);
    checks++; if (result_count !== 4'd0 || busy !== 1'b0 || done !== 1'b0 || result_ids[7:0] !== 8'hFF) begin
      errors++; $display("FAIL clear_commit got cnt=%0d busy=%b done=%b slot0=%h", result_count, busy, done, result_ids[7:0]); end
    send_str("dog", "g");
    beat(8'h00, 1'b1, 1'b0, 1'b0);
    checks++; if (result_count !== 4'd1 || result_ids[7:0] !== 8'd0) begin
      errors++; $display("FAIL clear_then_word got cnt=%0d slot0=%h want 1 00", result_count, result_ids[7:0]); end
  endtask

  task automatic test_random();
    for (int t = 0; t < 30; t++) begin
      int  ws, nw;
      int  lens[$];
      bit  lastm[$];
      ws = $urandom_range(0, 4);
      word_size = 8'(ws);
      nw = $urandom_range(1, 12);
      lens.delete(); lastm.delete();
      if ($urandom_range(0, 2) == 0) beat(8'h20, 1'b0, 1'($urandom_range(0, 1)), 1'b0);
      for (int w = 0; w < nw; w++) begin
        int  len;
        bit  m;
        len = $urandom_range(1, 5);
        m = 1'b0;
        for (int i = 0; i < len; i++) begin
          m = 1'($urandom_range(0, 1));
          beat(8'($urandom_range(97, 122)), 1'b0, m, 1'b0);
          if ($urandom_range(0, 3) == 0) idle_cycle();
        end
        lens.push_back(len); lastm.push_back(m);
        if (w != nw - 1 || $urandom_range(0, 1) == 1) begin
          for (int s = 0; s < int'($urandom_range(1, 2)); s++)
            beat(8'h20, 1'b0, 1'($urandom_range(0, 1)), 1'b0);
        end
      end
      model_text(ws, lens, lastm);
      beat(8'h00, 1'b1, 1'b0, 1'b0);
      checks++; if (result_count !== 4'(exp_cnt) || overflow !== exp_ovf || done !== 1'b1) begin
        errors++; $display("FAIL rand%0d_flags got cnt=%0d ovf=%b done=%b want %0d %b 1", t, result_count, overflow, done, exp_cnt, exp_ovf); end
      for (int k = 0; k < 8; k++) begin
        checks++; if (result_ids[k*8 +: 8] !== exp_slot[k]) begin
          errors++; $display("FAIL rand%0d_slot%0d got %h want %h", t, k, result_ids[k*8 +: 8], exp_slot[k]); end
      end
`ifdef SEARCH_RESULT_IRQ_EN
      checks++; if (irq !== ((exp_cnt > 0) || exp_ovf)) begin
        errors++; $display("FAIL rand%0d_irq got %b want %b", t, irq, (exp_cnt > 0) || exp_ovf); end
`endif
    end
  endtask

  initial begin
    aresetn = 1'b0; clear = 1'b0; word_size = 8'd3;
    s_axis_tvalid = 1'b0; s_axis_tdata = 8'h00; s_axis_tuser = 1'b0; match = 1'b0;
    test_reset();
    test_cat_dog();
    test_cats();
    test_overflow();
    test_restart();
    test_clear();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
